// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : btn_pkg
// Description : Shared types and defaults for the pushbutton conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

  // Debounce FSM states, one FSM per button channel
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_t;

  // 5 ms of stability at a 100 MHz system clock
  localparam int unsigned BTN_DEBOUNCE_CYCLES_DFLT = 500000;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_one.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_one
// Description : One button channel: synchronizer, debounce FSM with a
//               stability counter, registered level and press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_one
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DFLT,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  btn_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain bringing the asynchronous button into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  // Next-state, counter and output decode; the counter restarts on every state entry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    case (state_q)
      LOW: begin
        if (sync_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (!sync_s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next state so they align with the state change
    level_d   = (state_d == HIGH) || (state_d == WAIT_LOW);
    press_d   = (state_q == WAIT_HIGH) && (state_d == HIGH);
    release_d = (state_q == WAIT_LOW) && (state_d == LOW);
  end

  // State, counter and output registers; reset discards any partial count
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule : btn_debounce_one
`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_pulse
// Description : Multi-channel pushbutton conditioner; one independent
//               debounce channel per button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DFLT,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce_one #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .btn_i     (btn_in[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
    );
  end : g_btn

endmodule : btn_debounce_pulse
`default_nettype wire

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Multi-channel pushbutton conditioner for the board-level register-file/ALU test harness. Each raw, asynchronous button input is synchronized, debounced with a cycle-count filter, and turned into a clean level plus single-cycle press and release pulses. The pulses feed the harness's address-load and register-write control directly, so it needs no one-shot logic of its own.

## Interface
- NUM_BTNS, 4, number of independent button channels
- DEBOUNCE_CYCLES, 500000, cycles the synchronized input must stay stable before a change is accepted (5 ms at 100 MHz); legal range ≥ 2
- SYNC_STAGES, 2, synchronizer flop depth; legal range ≥ 2
- clk  input  1  100 MHz system clock
- reset  input  1  synchronous, active-high reset
- btn_in  input  NUM_BTNS  raw asynchronous button levels
- btn_level  output  NUM_BTNS  debounced level per channel
- btn_press  output  NUM_BTNS  one-cycle pulse on each accepted rising transition
- btn_release  output  NUM_BTNS  one-cycle pulse on each accepted falling transition

## Operation
- Channels are fully independent; the rules below apply per channel.
- Synchronizer: a chain of SYNC_STAGES flops. The last stage is the filtered input `s`.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. Each channel has one counter of width $clog2(DEBOUNCE_CYCLES).
- LOW: if s=1, go to WAIT_HIGH and set count=0.
- WAIT_HIGH:
  - if s=0, return to LOW (glitch rejected, no pulse);
  - else if count==DEBOUNCE_CYCLES-1, go to HIGH;
  - else increment count.
- HIGH: if s=0, go to WAIT_LOW and set count=0.
- WAIT_LOW: mirror of WAIT_HIGH with s inverted.
  - s=1 returns to HIGH.
  - A terminal count goes to LOW.
- btn_level=1 exactly in states HIGH and WAIT_LOW. It is registered and decoded from state.
- btn_press=1 for exactly the one cycle following the WAIT_HIGH→HIGH edge.
- btn_release=1 for exactly the one cycle following the WAIT_LOW→LOW edge.
- Counter never wraps. It is only compared against DEBOUNCE_CYCLES-1 and is cleared on every state entry.

## Timing
- Reset (synchronous):
  - synchronizer flops, counters and all outputs go to 0;
  - FSM goes to LOW.
- Reset has priority over every transition, including mid-count. A partially counted press is discarded.
- A button held through reset is treated as a fresh press after reset deasserts. It produces one btn_press after the full latency.
- Press latency: input stable high, first captured at edge 1 → btn_level and btn_press high after edge SYNC_STAGES+1+DEBOUNCE_CYCLES.
- Release latency is identical, applied to btn_level falling and btn_release.
- Any bounce shorter than DEBOUNCE_CYCLES consecutive stable cycles of `s` produces no output change.
- btn_press and btn_release are never both high on one channel in one cycle.
- Two accepted pulses on one channel are separated by at least DEBOUNCE_CYCLES+1 cycles.
- Simultaneous presses on different channels each produce their own pulse in the same cycle. There is no arbitration.

## Structure
- Package btn_pkg holds:
  - the state typedef (enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW});
  - a default DEBOUNCE_CYCLES localparam for 100 MHz.
- Sub-module btn_debounce_one: one synchronizer, FSM and counter, with ports clk, reset, btn_in, level, press, release.
- The top level is a generate loop of NUM_BTNS instances and nothing else.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
- Reset: assert reset with btn_in=4'hF → all outputs 0 during reset. After deassert, btn_press=4'hF for one cycle after edge 7, and btn_level=4'hF stays high.
- Clean press: btn_in[0] goes 0→1 and holds → btn_level[0] rises and btn_press[0] pulses for 1 cycle after edge 7. No btn_release.
- Bounce rejection: btn_in[1] toggles 1,0,1,1,0 on consecutive cycles, then holds 0 → btn_level[1], btn_press[1] and btn_release[1] stay 0 throughout.
- Release after bounce: from HIGH, btn_in[2] drops 2 cycles, rises 1 cycle, then stays low → exactly one btn_release[2] pulse, at 7 edges after the final fall.
- Reset mid-count: raise btn_in[3], then assert reset at edge 5 for 1 cycle → no pulse before reset. A single btn_press[3] appears 7 edges after deassert.
- Simultaneous: btn_in 4'b0000→4'b0101 on the same cycle → btn_press=4'b0101 for one cycle after edge 7, and other bits stay 0.
